// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes MIPS instruction fields into 32-bit words and
// streams them into the instruction memory write port, one word per accepted bundle.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              err_illegal
);
    localparam int CNT_W = ADDR_W + 1;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d, waddr_q, waddr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       wdata_q, wdata_d, enc;
    logic              we_q, we_d, err_q, err_d;
    logic              xfer, legal, wr, last;
    logic [5:0]        opc;
    always_comb begin
        opc = 6'b000000;
        case (in_op)
            4'd1:    opc = 6'b100011;
            4'd2:    opc = 6'b101011;
            4'd3:    opc = 6'b000100;
            4'd4:    opc = 6'b001100;
            4'd5:    opc = 6'b001101;
            4'd6:    opc = 6'b001110;
            4'd7:    opc = 6'b001000;
            4'd8:    opc = 6'b001010;
            4'd9:    opc = 6'b000101;
            4'd10:   opc = 6'b000110;
            4'd11:   opc = 6'b000111;
            4'd12:   opc = 6'b001111;
            4'd13:   opc = 6'b000010;
            default: opc = 6'b000000;
        endcase
    end
    // BLEZ/BGTZ have no rt operand and LUI has no rs operand, so those fields are zeroed.
    assign enc = (in_op == 4'd0)  ? {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct} :
                 (in_op == 4'd13) ? {opc, in_target} :
                 {opc, (in_op == 4'd12) ? 5'd0 : in_rs,
                       (in_op == 4'd10 || in_op == 4'd11) ? 5'd0 : in_rt, in_imm};
    // A bundle arriving with a restart belongs to the abandoned session and is discarded.
    assign xfer  = in_valid && in_ready && !start;
    assign legal = in_op < 4'd14;
    assign wr    = xfer && legal;
    assign last  = wr && (count_q == CNT_W'(DEPTH - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (start)                             state_d = S_RUN;
        else if (finish && state_q != S_IDLE)  state_d = S_IDLE;
        else if (state_q == S_RUN && last)     state_d = S_FULL;
    end
    always_comb begin
        in_ready = state_q == S_RUN;
        busy     = state_q != S_IDLE;
        full     = state_q == S_FULL;
    end
    always_comb begin
        count_d     = start ? '0 : wr ? count_q + 1'b1 : count_q;
        next_addr_d = start ? ADDR_W'(BASE_ADDR) : wr ? next_addr_q + 1'b1 : next_addr_q;
        err_d       = start ? 1'b0 : (xfer && !legal) ? 1'b1 : err_q;
        we_d        = wr;
        waddr_d     = wr ? next_addr_q : waddr_q;
        wdata_d     = wr ? enc : wdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            next_addr_q <= ADDR_W'(BASE_ADDR);
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= ADDR_W'(BASE_ADDR);
            wdata_q     <= '0;
        end else begin
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end
    assign imem_we     = we_q;
    assign imem_addr   = waddr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign err_illegal = err_q;
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: turns instruction fields plus an operation select into 32-bit MIPS instruction words.
- Writes those words sequentially into the single-cycle core's instruction memory through its write port.
- Used by testbenches and the boot path to load programs. Input side uses a valid/ready handshake; output side is a one-cycle registered write pulse.

Parameters:
- ADDR_W, 8, word-address width of imem write port
- BASE_ADDR, 0, first word address written after start
- DEPTH, 256, max words per load session (1..2^ADDR_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  pulse: begin/restart load session at BASE_ADDR
- finish  in  1  pulse: end session, return to IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_op  in  4  0 R, 1 LW, 2 SW, 3 BEQ, 4 ANDI, 5 ORI, 6 XORI, 7 ADDI, 8 SLTI, 9 BNE, 10 BLEZ, 11 BGTZ, 12 LUI, 13 J, 14-15 illegal
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type function
- in_imm  in  16  immediate/offset
- in_target  in  26  jump target
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- full  out  1  DEPTH words written
- busy  out  1  state != IDLE
- err_illegal  out  1  sticky: illegal op accepted this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, imem_we, full, busy, err_illegal = 0; count = 0; imem_addr = BASE_ADDR; imem_wdata = 0. Any in-flight write is dropped.
- States: IDLE, RUN, FULL.
  - IDLE: in_ready = 0. start → RUN; clears count, full and err_illegal; next address = BASE_ADDR.
  - RUN: in_ready = 1. A transfer occurs when in_valid && in_ready.
  - FULL: in_ready = 0, full = 1.
- Transitions:
  - start in RUN or FULL restarts the session as from IDLE; a write already registered still completes at its old address.
  - finish in RUN or FULL → IDLE. start has priority over finish.
- Latency: a transfer at edge N produces imem_we=1 with addr/wdata during cycle N+1, for exactly one cycle per accepted legal bundle. Back-to-back transfers give continuous imem_we.
- Address: first write at BASE_ADDR, then +1 per legal write, wrapping modulo 2^ADDR_W. count increments in the same cycle imem_we is asserted.
- Reaching DEPTH: when the DEPTH-th legal bundle is accepted, the state moves to FULL at that edge, so no extra bundle is accepted. full asserts with the last imem_we.
- Illegal op (14/15): bundle accepted (handshake completes), no write, count unchanged, err_illegal set until the next start or reset.
- Encoding, opcode in [31:26]:
  - R: {000000, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}. Opcodes: LW 100011, SW 101011, BEQ 000100, BNE 000101, ANDI 001100, ORI 001101, XORI 001110, ADDI 001000, SLTI 001010.
  - BLEZ 000110 and BGTZ 000111: rt field forced to 0.
  - LUI 001111: rs field forced to 0.
  - J: {000010, target}.
- No field range checks beyond the forcing above; unused input fields are ignored.

Test Plan:
- Reset → start, op R rs=1 rt=2 rd=3 shamt=0 funct=0x20 → next cycle imem_we=1, addr=0x00, wdata=0x00221820, count=1.
- Back-to-back LW rs=1 rt=2 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x10 → writes 0x8C220004 @0, 0x1022FFFF @1, 0x08000010 @2 on consecutive cycles.
- LUI rs=7 rt=5 imm=0x1234 → 0x3C051234 (rs forced 0). BLEZ rs=4 rt=9 imm=8 → 0x18800008.
- DEPTH=4, in_valid held high → exactly 4 writes (addr 0..3), full=1 and in_ready=0 from the cycle after the 4th accept; finish → IDLE, busy=0.
- op=15 accepted between two legal ops → no write for it, legal writes at addr 0 and 1, err_illegal=1; start → err_illegal=0, count=0.
- rst_n low in the cycle imem_we=1 → imem_we drops immediately, count=0, state IDLE; after release, a new start writes at BASE_ADDR.
